// File: rtl/div_pkg.sv
// Shared definitions for the 4-bit restoring divider control unit:
// FSM state encoding and the default iteration count.
package div_pkg;

   localparam int DIV_N_DEFAULT = 4;

   typedef logic [2:0] div_state_t;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] SHIFT  = 3'd2;
   localparam logic [2:0] UPDATE = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

endpackage

// File: rtl/div_cu.sv
// Control unit for the restoring integer divider.
// Sequences LOAD, then WIDTH x (SHIFT, UPDATE), then DONE; a zero divisor
// seen at the start request goes to ERR instead.
// Optional build macro DIV_CU_PERF_EN adds the cycles[7:0] output, which
// counts the clocks spent in LOAD..UPDATE by the most recent operation.
module div_cu
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_N_DEFAULT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       error,
   input  logic       r_lt_y,
   input  logic [3:0] cnt_out,
   output logic       ld_r,
   output logic       ld_x,
   output logic       ld_y,
   output logic       sl_r,
   output logic       sl_x,
   output logic       sr,
   output logic       right_in_x,
   output logic       sel1,
   output logic       sel2,
   output logic       ld_cnt,
   output logic       ud,
   output logic       ce,
   output logic [3:0] n,
   output logic       busy,
   output logic       done,
   output logic       err_flag
`ifdef DIV_CU_PERF_EN
   ,
   output logic [7:0] cycles
`endif
);

   div_state_t state;
   div_state_t state_nxt;

   // Right shift and up-counting are never used by this algorithm.
   assign sr = 1'b0;
   assign ud = 1'b0;
   assign n  = 4'(WIDTH);

   // State register; reset drops any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; unused encodings fall back to IDLE.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = go ? (error ? ERR : LOAD) : IDLE;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   state_nxt = UPDATE;
         // cnt_out is the pre-decrement value, so 1 marks the last iteration
         UPDATE:  state_nxt = (cnt_out == 4'd1) ? DONE : SHIFT;
         DONE:    state_nxt = go ? (error ? ERR : LOAD) : DONE;
         ERR:     state_nxt = (go && !error) ? LOAD : ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: Moore, except the restore decision in UPDATE.
   always_comb begin
      ld_r       = 1'b0;
      ld_x       = 1'b0;
      ld_y       = 1'b0;
      sl_r       = 1'b0;
      sl_x       = 1'b0;
      right_in_x = 1'b0;
      sel1       = 1'b0;
      sel2       = 1'b1;
      ld_cnt     = 1'b0;
      ce         = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err_flag   = 1'b0;
      case (state)
         LOAD: begin
            busy   = 1'b1;
            ld_x   = 1'b1;
            ld_y   = 1'b1;
            ld_r   = 1'b1;
            sel1   = 1'b1;
            ld_cnt = 1'b1;
         end
         SHIFT: begin
            busy = 1'b1;
            sl_r = 1'b1;
         end
         UPDATE: begin
            busy       = 1'b1;
            sl_x       = 1'b1;
            ce         = 1'b1;
            right_in_x = ~r_lt_y;
            // R >= Y: keep the difference, otherwise R is left untouched
            ld_r       = ~r_lt_y;
         end
         DONE: begin
            done = 1'b1;
            sel2 = 1'b0;
         end
         ERR: begin
            err_flag = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef DIV_CU_PERF_EN
   // Operation length counter: cleared when an operation is accepted,
   // advances while busy, holds otherwise, saturates at 255.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          cycles <= 8'd0;
      else if (state_nxt == LOAD)        cycles <= 8'd0;
      else if (busy && cycles != 8'hFF)  cycles <= cycles + 8'd1;
   end
`endif

endmodule

// File: tb/tb_div_cu.sv
// Bench for div_cu wired to a behavioural model of the 4-bit restoring
// divider datapath. Results are compared against plain a/b and a%b and
// against the go-to-done timing of the control unit.
module tb_div_cu;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       go = 1'b0;
   logic       error, r_lt_y;
   logic [3:0] cnt_out;
   logic       ld_r, ld_x, ld_y, sl_r, sl_x, sr, right_in_x, sel1, sel2;
   logic       ld_cnt, ud, ce, busy, done, err_flag;
   logic [3:0] n;
`ifdef DIV_CU_PERF_EN
   logic [7:0] cycles;
`endif

   logic [3:0] x_in = 4'd0;
   logic [3:0] y_in = 4'd1;
   logic [4:0] r_q = 5'd0;
   logic [3:0] x_q = 4'd0;
   logic [3:0] y_q = 4'd0;
   logic [3:0] cnt_q = 4'd0;
   logic [3:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_cu #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .go(go), .error(error), .r_lt_y(r_lt_y),
      .cnt_out(cnt_out), .ld_r(ld_r), .ld_x(ld_x), .ld_y(ld_y),
      .sl_r(sl_r), .sl_x(sl_x), .sr(sr), .right_in_x(right_in_x),
      .sel1(sel1), .sel2(sel2), .ld_cnt(ld_cnt), .ud(ud), .ce(ce),
      .n(n), .busy(busy), .done(done), .err_flag(err_flag)
`ifdef DIV_CU_PERF_EN
      , .cycles(cycles)
`endif
   );

   // Datapath model
   assign error     = (y_in == 4'd0);
   assign r_lt_y    = (r_q < {1'b0, y_q});
   assign cnt_out   = cnt_q;
   assign quotient  = sel2 ? 4'd0 : x_q;
   assign remainder = sel2 ? 4'd0 : r_q[3:0];

   always @(posedge clk) begin
      if (ld_x)      x_q <= x_in;
      else if (sl_x) x_q <= {x_q[2:0], right_in_x};
      if (ld_y)      y_q <= y_in;
      if (ld_r)      r_q <= sel1 ? 5'd0 : (r_q - {1'b0, y_q});
      else if (sl_r) r_q <= {r_q[3:0], x_q[3]};
      if (ld_cnt)    cnt_q <= n;
      else if (ce)   cnt_q <= ud ? (cnt_q + 4'd1) : (cnt_q - 4'd1);
   end

   // Issue one operation; returns observations, no checking here.
   // lat = clock edges after the edge that sampled go until done/err_flag.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit noise,
                         output int lat, output int bcnt, output logic [3:0] q,
                         output logic [3:0] r, output bit early_zero, output bit got_err);
      @(negedge clk);
      x_in = a; y_in = b; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      lat = 0; bcnt = 0; early_zero = 1'b1;
      while (!done && !err_flag && lat < 40) begin
         bcnt += int'(busy);
         if (quotient != 4'd0 || remainder != 4'd0) early_zero = 1'b0;
         if (noise && lat < 8) begin
            go = 1'($urandom_range(0, 1));
            if (lat >= 1) y_in = 4'($urandom_range(0, 15));
         end else begin
            go = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      go = 1'b0;
      q = quotient; r = remainder; got_err = err_flag;
   endtask

   task automatic test_reset();
      logic [10:0] ctrl;
      #1;
      ctrl = {ld_r, ld_x, ld_y, sl_r, sl_x, sr, right_in_x, sel1, ld_cnt, ud, ce};
      checks++;
      if (ctrl !== 11'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 11'b0); end
      checks++;
      if ({sel2, busy, done, err_flag} !== 4'b1000) begin
         errors++; $display("FAIL reset_status: got %b expected 1000", {sel2, busy, done, err_flag});
      end
      checks++;
      if (n !== 4'd4) begin errors++; $display("FAIL reset_n: got %0d expected 4", n); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, err_flag} !== 3'b000) begin
         errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, err_flag});
      end
   endtask

   task automatic test_basic();
      logic [3:0] av [3] = '{4'd13, 4'd15, 4'd7};
      logic [3:0] bv [3] = '{4'd4, 4'd1, 4'd9};
      int lat, bcnt;
      logic [3:0] q, r;
      bit ez, ge;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], 1'b0, lat, bcnt, q, r, ez, ge);
         checks++;
         if (lat !== 9) begin errors++; $display("FAIL basic_latency %0d/%0d: got %0d expected 9", av[i], bv[i], lat); end
         checks++;
         if (bcnt !== 9) begin errors++; $display("FAIL basic_busy %0d/%0d: got %0d expected 9", av[i], bv[i], bcnt); end
         checks++;
         if (q !== av[i] / bv[i] || r !== av[i] % bv[i]) begin
            errors++; $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                               av[i], bv[i], q, r, av[i] / bv[i], av[i] % bv[i]);
         end
         checks++;
         if (!ez) begin errors++; $display("FAIL basic_outputs_zero_before_done %0d/%0d: got nonzero expected 0", av[i], bv[i]); end
`ifdef DIV_CU_PERF_EN
         checks++;
         if (cycles !== 8'd9) begin errors++; $display("FAIL perf_cycles: got %0d expected 9", cycles); end
`endif
         @(negedge clk);
         checks++;
         if (done !== 1'b1 || quotient !== av[i] / bv[i]) begin
            errors++; $display("FAIL done_hold: got done=%b q=%0d expected done=1 q=%0d", done, quotient, av[i] / bv[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      bit saw_load = 1'b0;
      int lat, bcnt;
      logic [3:0] q, r;
      bit ez, ge;
      @(negedge clk);
      x_in = 4'd5; y_in = 4'd0; go = 1'b1;
      saw_load = saw_load | ld_x | ld_y;
      @(negedge clk);
      go = 1'b0;
      checks++;
      if ({err_flag, busy, done} !== 3'b100) begin
         errors++; $display("FAIL err_entry: got err/busy/done=%b expected 100", {err_flag, busy, done});
      end
      checks++;
      if (quotient !== 4'd0 || remainder !== 4'd0) begin
         errors++; $display("FAIL err_outputs: got q=%0d r=%0d expected 0 0", quotient, remainder);
      end
      for (int i = 0; i < 3; i++) begin
         saw_load = saw_load | ld_x | ld_y;
         @(negedge clk);
      end
      checks++;
      if (saw_load || err_flag !== 1'b1) begin
         errors++; $display("FAIL err_hold: got ld_seen=%b err_flag=%b expected 0 1", saw_load, err_flag);
      end
      run_op(4'd6, 4'd3, 1'b0, lat, bcnt, q, r, ez, ge);
      checks++;
      if (ge || lat !== 9 || q !== 4'd2 || r !== 4'd0) begin
         errors++; $display("FAIL err_recover: got err=%b lat=%0d q=%0d r=%0d expected 0 9 2 0", ge, lat, q, r);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int wait_cnt = 0;
      @(negedge clk);
      x_in = 4'd9; y_in = 4'd2; go = 1'b1;
      for (int t = 0; t < 35; t++) begin
         @(negedge clk);
         checks++;
         if (done !== ((t % 10) == 9)) begin
            errors++; $display("FAIL b2b_done_t%0d: got %b expected %b", t, done, (t % 10) == 9);
         end
         if (done) begin
            ndone++;
            checks++;
            if (quotient !== 4'd4 || remainder !== 4'd1) begin
               errors++; $display("FAIL b2b_result: got q=%0d r=%0d expected 4 1", quotient, remainder);
            end
         end
      end
      go = 1'b0;
      checks++;
      if (ndone !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
      while (!done && wait_cnt < 30) begin @(negedge clk); wait_cnt++; end
      checks++;
      if (!done) begin errors++; $display("FAIL b2b_drain: got done=0 expected 1"); end
   endtask

   task automatic test_abort_reset();
      logic [10:0] ctrl;
      int lat, bcnt;
      logic [3:0] q, r;
      bit ez, ge;
      @(negedge clk);
      x_in = 4'd12; y_in = 4'd5; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || sl_r !== 1'b1) begin
         errors++; $display("FAIL abort_in_shift: got busy=%b sl_r=%b expected 1 1", busy, sl_r);
      end
      rst = 1'b0;
      #1;
      ctrl = {ld_r, ld_x, ld_y, sl_r, sl_x, sr, right_in_x, sel1, ld_cnt, ud, ce};
      checks++;
      if (ctrl !== 11'b0 || {sel2, busy, done, err_flag} !== 4'b1000 || quotient !== 4'd0 || remainder !== 4'd0) begin
         errors++; $display("FAIL abort_async: got ctrl=%b status=%b q=%0d r=%0d expected 0 1000 0 0",
                            ctrl, {sel2, busy, done, err_flag}, quotient, remainder);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, err_flag} !== 3'b000) begin
         errors++; $display("FAIL abort_idle: got %b expected 000", {busy, done, err_flag});
      end
      run_op(4'd12, 4'd5, 1'b0, lat, bcnt, q, r, ez, ge);
      checks++;
      if (lat !== 9 || q !== 4'd2 || r !== 4'd2) begin
         errors++; $display("FAIL abort_rerun: got lat=%0d q=%0d r=%0d expected 9 2 2", lat, q, r);
      end
   endtask

   task automatic test_random();
      int lat, bcnt;
      logic [3:0] a, b, q, r;
      bit ez, ge;
      for (int i = 0; i < 25; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         run_op(a, b, 1'b1, lat, bcnt, q, r, ez, ge);
         checks++;
         if (b == 4'd0) begin
            if (!ge || lat !== 0 || q !== 4'd0 || r !== 4'd0) begin
               errors++; $display("FAIL rand_zero %0d/0: got err=%b lat=%0d q=%0d r=%0d expected 1 0 0 0", a, ge, lat, q, r);
            end
         end else begin
            if (ge || lat !== 9 || q !== a / b || r !== a % b) begin
               errors++; $display("FAIL rand_div %0d/%0d: got err=%b lat=%0d q=%0d r=%0d expected 0 9 %0d %0d",
                                  a, b, ge, lat, q, r, a / b, a % b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_by_zero();
      test_back_to_back();
      test_abort_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
